// File: rtl/accbin_pkg.sv
// Shared types and width helpers for the time-multiplexed accumulate/binarise stage.
package accbin_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int acc_width(input int bw, input int taps);
    return bw + $clog2(taps) + 1;
  endfunction

  function automatic int idx_width(input int ch, input int pix);
    return (ch * pix > 1) ? $clog2(ch * pix) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/accbin_outreg.sv
// Single-entry output register: loads a result, holds it until the consumer takes it.
module accbin_outreg #(
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          load_i,
  input  logic          bit_i,
  input  logic [IW-1:0] idx_i,
  input  logic          last_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic          bit_o,
  output logic [IW-1:0] idx_o,
  output logic          last_o
);

  logic          valid_q, valid_d;
  logic          bit_q, bit_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          last_q, last_d;

  always_comb begin
    valid_d = valid_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      // A load may coincide with the drain of the previous entry; the new result wins.
      valid_d = 1'b1;
      bit_d   = bit_i;
      idx_d   = idx_i;
      last_d  = last_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      bit_q   <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign bit_o   = bit_q;
  assign idx_o   = idx_q;
  assign last_o  = last_q;

endmodule

// File: rtl/accbin_stream.sv
// Streams TAPS signed partials per pixel, adds the channel offset and emits the sign bit,
// channel-major over CH x PIX pixels per frame.
module accbin_stream
  import accbin_pkg::*;
#(
  parameter int bW   = 8,
  parameter int TAPS = 5,
  parameter int CH   = 18,
  parameter int PIX  = 576,
  localparam int AW  = acc_width(bW, TAPS),
  localparam int IW  = idx_width(CH, PIX)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic [CH*bW-1:0]   kernel_offset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [bW-1:0]      s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_bit,
  output logic [IW-1:0]      m_idx,
  output logic               m_last,
  output logic               frame_done
);

  localparam int TW = cnt_width(TAPS);
  localparam int PW = cnt_width(PIX);
  localparam int CW = cnt_width(CH);
  localparam logic [TW-1:0] TAP_MAX = TW'(TAPS - 1);
  localparam logic [PW-1:0] PIX_MAX = PW'(PIX - 1);
  localparam logic [CW-1:0] CH_MAX  = CW'(CH - 1);

  state_e                 state_q, state_d;
  logic [TW-1:0]          tap_cnt_q, tap_cnt_d;
  logic [PW-1:0]          pix_cnt_q, pix_cnt_d;
  logic [CW-1:0]          ch_cnt_q, ch_cnt_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [CH*bW-1:0]       off_q, off_d;
  logic                   frame_done_q, frame_done_d;

  logic                   tap_last, pix_last, ch_last, frame_end;
  logic                   fire, frame_start, load;
  logic [CH*bW-1:0]       off_cur;
  logic [bW-1:0]          off_sel;
  logic signed [AW-1:0]   data_ext, off_ext, acc_base, acc_sum, pix_sum;
  logic [IW-1:0]          idx_cur;

  assign tap_last  = (tap_cnt_q == TAP_MAX);
  assign pix_last  = (pix_cnt_q == PIX_MAX);
  assign ch_last   = (ch_cnt_q == CH_MAX);
  assign frame_end = tap_last && pix_last && ch_last;

  assign s_ready     = (state_q != DRAIN) && !(tap_last && m_valid && !m_ready);
  assign fire        = s_valid && s_ready && !clear;
  assign frame_start = fire && (state_q == IDLE);
  assign load        = fire && tap_last;

  // The first beat of a frame must already see the freshly presented offsets.
  assign off_cur = frame_start ? kernel_offset : off_q;
  assign off_d   = off_cur;

  always_comb begin
    off_sel  = off_cur[int'(ch_cnt_q)*bW +: bW];
    data_ext = {{(AW-bW){s_data[bW-1]}}, s_data};
    off_ext  = {{(AW-bW){off_sel[bW-1]}}, off_sel};
    acc_base = (tap_cnt_q == '0) ? '0 : acc_q;
    acc_sum  = acc_base + data_ext;
    pix_sum  = acc_sum + off_ext;
    idx_cur  = IW'(ch_cnt_q) * IW'(PIX) + IW'(pix_cnt_q);
  end

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    tap_cnt_d = tap_cnt_q;
    pix_cnt_d = pix_cnt_q;
    ch_cnt_d  = ch_cnt_q;
    acc_d     = acc_q;
    if (clear) begin
      tap_cnt_d = '0;
      pix_cnt_d = '0;
      ch_cnt_d  = '0;
      acc_d     = '0;
    end else if (fire) begin
      acc_d = acc_sum;
      if (tap_last) begin
        tap_cnt_d = '0;
        if (pix_last) begin
          pix_cnt_d = '0;
          ch_cnt_d  = ch_last ? '0 : ch_cnt_q + CW'(1);
        end else begin
          pix_cnt_d = pix_cnt_q + PW'(1);
        end
      end else begin
        tap_cnt_d = tap_cnt_q + TW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fire) state_d = frame_end ? DRAIN : ACC;
      ACC:     if (fire && frame_end) state_d = DRAIN;
      DRAIN:   if (m_valid && m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  assign frame_done_d = m_valid && m_ready && m_last && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tap_cnt_q    <= '0;
      pix_cnt_q    <= '0;
      ch_cnt_q     <= '0;
      acc_q        <= '0;
      // NOTE: the offset bank is small enough to reset; clear deliberately leaves it alone.
      off_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tap_cnt_q    <= tap_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      ch_cnt_q     <= ch_cnt_d;
      acc_q        <= acc_d;
      off_q        <= off_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done = frame_done_q;

  accbin_outreg #(.IW(IW)) u_outreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear),
    .load_i  (load),
    .bit_i   (~pix_sum[AW-1]),
    .idx_i   (idx_cur),
    .last_i  (frame_end),
    .ready_i (m_ready),
    .valid_o (m_valid),
    .bit_o   (m_bit),
    .idx_o   (m_idx),
    .last_o  (m_last)
  );

endmodule
